// File: rtl/fixed_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks (Q(M.N) sign-magnitude).
package fixed_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fixed_div_state_t;

    // Full word width: sign bit plus magnitude
    function automatic int word_width(input int n, input int m);
        return n + m + 1;
    endfunction

    // Magnitude width: integer plus fraction bits
    function automatic int mag_width(input int n, input int m);
        return n + m;
    endfunction

    // Saturated magnitude source; slice the low MW bits where needed
    localparam logic [63:0] SAT_ONES = {64{1'b1}};

endpackage

// File: rtl/fixed_div_step.sv
// One restoring-division cell: shift in the next dividend bit and subtract
// the divisor when the trial remainder is large enough.
module fixed_div_step #(
    parameter int MW = 31
) (
    input  logic [MW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [MW-1:0] div_i,
    output logic [MW-1:0] rem_o,
    output logic          qbit_o
);

    logic [MW:0] trial;
    logic [MW:0] diff;

    // Trial subtraction; the remainder is always below the divisor so the
    // restored/updated value fits back into MW bits.
    always_comb begin
        trial  = {rem_i, bit_i};
        diff   = trial - {1'b0, div_i};
        qbit_o = (trial >= {1'b0, div_i});
        rem_o  = qbit_o ? diff[MW-1:0] : trial[MW-1:0];
    end

endmodule

// File: rtl/fixed_div.sv
// Sequential signed fixed-point divider, one quotient bit per cycle.
// Optional build macro: FIXED_DIV_ROUND_EN (one extra iteration, round half up).
module fixed_div
    import fixed_pkg::*;
#(
    parameter int N = 23,
    parameter int M = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N+M:0]   a,
    input  logic [N+M:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N+M:0]   q,
    output logic           ovf,
    output logic           dbz
);

    localparam int W  = word_width(N, M);
    localparam int MW = mag_width(N, M);
`ifdef FIXED_DIV_ROUND_EN
    localparam int K  = MW + N + 1;
`else
    localparam int K  = MW + N;
`endif
    localparam int CW = $clog2(K);
    localparam logic [CW-1:0] LAST = CW'(K - 1);
    localparam logic [MW-1:0] SAT  = SAT_ONES[MW-1:0];

    fixed_div_state_t state_q, state_d;
    logic            alive_q;
    logic [CW-1:0]   cnt_q,  cnt_d;
    logic [MW-1:0]   rem_q,  rem_d;
    logic [K-1:0]    dvd_q,  dvd_d;
    logic [MW-1:0]   div_q,  div_d;
    logic [K-2:0]    quo_q,  quo_d;
    logic            sign_q, sign_d;
    logic [W-1:0]    q_q,    q_d;
    logic            ovf_q,  ovf_d;
    logic            dbz_q,  dbz_d;

    logic [MW-1:0]   step_rem;
    logic            step_qbit;
    logic [K-1:0]    quo_nxt;
    logic [MW-1:0]   mag_raw;
    logic [MW-1:0]   res_mag;
    logic            res_ovf;
    logic            res_sign;

    fixed_div_step #(.MW(MW)) u_step (
        .rem_i  (rem_q),
        .bit_i  (dvd_q[K-1]),
        .div_i  (div_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    // Final result formatting from the quotient including this cycle's bit
    always_comb begin
        quo_nxt = {quo_q, step_qbit};
`ifdef FIXED_DIV_ROUND_EN
        begin
            logic [MW:0] rnd_sum;
            rnd_sum = {1'b0, quo_nxt[MW:1]} + {{MW{1'b0}}, quo_nxt[0]};
            res_ovf = (|quo_nxt[K-1:MW+1]) | rnd_sum[MW];
            mag_raw = rnd_sum[MW-1:0];
        end
`else
        res_ovf = |quo_nxt[K-1:MW];
        mag_raw = quo_nxt[MW-1:0];
`endif
        res_mag  = res_ovf ? SAT : mag_raw;
        res_sign = (res_mag == '0) ? 1'b0 : sign_q;
    end

    // Next-state and datapath update; handshake outputs decode the state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        div_d     = div_q;
        quo_d     = quo_q;
        sign_d    = sign_q;
        q_d       = q_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;
        in_ready  = (state_q == IDLE) && alive_q;
        out_valid = (state_q == DONE);
        unique case (state_q)
            IDLE: begin
                if (in_valid && alive_q) begin
                    div_d  = b[MW-1:0];
                    dvd_d  = {a[MW-1:0], {(K-MW){1'b0}}};
                    rem_d  = '0;
                    quo_d  = '0;
                    cnt_d  = '0;
                    sign_d = a[W-1] ^ b[W-1];
                    if (b[MW-1:0] == '0) begin
                        state_d = DONE;
                        q_d     = {a[W-1], SAT};
                        ovf_d   = 1'b0;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[K-2:0], 1'b0};
                quo_d = quo_nxt[K-2:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    q_d     = {res_sign, res_mag};
                    ovf_d   = res_ovf;
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight division
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            alive_q <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            sign_q  <= 1'b0;
            q_q     <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            sign_q  <= sign_d;
            q_q     <= q_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign q   = q_q;
    assign ovf = ovf_q;
    assign dbz = dbz_q;

endmodule

// File: tb/tb_fixed_div.sv
// Self-checking bench for fixed_div (N=23, M=8): directed cases plus random operands
// compared against an arithmetic reference model.
module tb_fixed_div;

    localparam int N  = 23;
    localparam int M  = 8;
    localparam int W  = 32;
    localparam int MW = 31;
`ifdef FIXED_DIV_ROUND_EN
    localparam int K  = MW + N + 1;
`else
    localparam int K  = MW + N;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  q;
    logic          ovf;
    logic          dbz;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0]  exp_q;
    logic          exp_ovf;
    logic          exp_dbz;
    logic [W-1:0]  cur_a;
    logic [W-1:0]  cur_b;

    fixed_div #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    // Reference: exact integer quotient of the scaled magnitudes
    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output logic [W-1:0] rq, output logic rovf, output logic rdbz);
        longint unsigned am, bm, qq, maxmag;
        logic [MW-1:0] mag;
        am     = longint'(av[MW-1:0]);
        bm     = longint'(bv[MW-1:0]);
        maxmag = (64'd1 << MW) - 1;
        rovf   = 1'b0;
        rdbz   = 1'b0;
        if (bm == 0) begin
            rdbz = 1'b1;
            rq   = {av[W-1], maxmag[MW-1:0]};
        end else begin
`ifdef FIXED_DIV_ROUND_EN
            qq = (((am << (N + 1)) / bm) + 1) >> 1;
`else
            qq = (am << N) / bm;
`endif
            if (qq > maxmag) begin
                rovf = 1'b1;
                qq   = maxmag;
            end
            mag = qq[MW-1:0];
            rq  = {(mag != 0) ? (av[W-1] ^ bv[W-1]) : 1'b0, mag};
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands and complete the input handshake
    task automatic start_div(input logic [W-1:0] av, input logic [W-1:0] bv);
        model(av, bv, exp_q, exp_ovf, exp_dbz);
        cur_a = av;
        cur_b = bv;
        @(negedge clk);
        chk("in_ready_before_start", in_ready, 1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Wait (bounded) for the result, check it and its latency, then consume it
    task automatic finish_div(input string tag, input int waited);
        int n;
        n = waited;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".out_valid"}, out_valid, 1);
        if (waited == 1) chk({tag, ".latency"}, n, exp_dbz ? 1 : K + 1);
        chk({tag, ".q"}, q, exp_q);
        chk({tag, ".ovf"}, ovf, exp_ovf);
        chk({tag, ".dbz"}, dbz, exp_dbz);
        $display("txn %s a=%h b=%h q=%h ovf=%0b dbz=%0b latency=%0d",
                 tag, cur_a, cur_b, q, ovf, dbz, n);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".drained"}, out_valid, 0);
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
        start_div(av, bv);
        finish_div(tag, 1);
    endtask

    initial begin
        logic [W-1:0] held_q;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        chk("rst.in_ready", in_ready, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.q", q, 0);
        chk("rst.ovf", ovf, 0);
        chk("rst.dbz", dbz, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.in_ready_after", in_ready, 1);

        run_div("basic",      32'h00C00000, 32'h00400000);
        run_div("neg",        32'h80C00000, 32'h00400000);
        run_div("negzero",    32'h80000000, 32'h80400000);
        run_div("ovf_pos",    32'h64000000, 32'h00400000);
        run_div("ovf_neg",    32'hE4000000, 32'h00400000);
        run_div("dbz",        32'h00800000, 32'h80000000);
        run_div("third",      32'h00800000, 32'h01800000);

        // Backpressure: result and in_ready hold while new operands are offered
        start_div(32'h01000000, 32'h00300000);
        while (!out_valid && vectors < 100000) begin
            @(negedge clk);
            if (!out_valid) chk("bp.busy_in_ready", in_ready, 0);
        end
        held_q = exp_q;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            chk("bp.q_stable", q, held_q);
            chk("bp.in_ready", in_ready, 0);
            chk("bp.out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        finish_div("backpressure", 11);

        // Reset in the middle of a calculation
        start_div(32'h00C00000, 32'h00400000);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.q", q, 0);
        chk("midrst.in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst.in_ready_after", in_ready, 1);
        run_div("after_rst", 32'h81400000, 32'h80A00000);

        // Random operands over a spread of magnitudes
        for (int i = 0; i < 24; i++) begin
            ra = {1'($urandom), 31'($urandom >> $urandom_range(1, 31))};
            rb = {1'($urandom), 31'($urandom >> $urandom_range(1, 31))};
            if (i % 8 == 5) rb[MW-1:0] = '0;
            run_div($sformatf("rand%0d", i), ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fixed_div.md
# fixed_div

Sequential signed fixed-point divider, the inverse of `fixed_mult`, using the same Q(M.N) sign-magnitude word.
- Computes `a / b` by restoring division, one quotient bit per cycle.
- Uses valid/ready handshakes on input and output.
- Sits beside `fixed_mult` in the arithmetic datapath for normalisation and reciprocal operations, where a multi-cycle latency is acceptable.

## Interface
Parameters:
- `N`, 23, fraction bits
- `M`, 8, integer bits
- Derived: W = N+M+1 (word width); MW = N+M (magnitude width). Bit W-1 is the sign; bits MW-1:0 are the magnitude.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operands present
- `in_ready`  out  1  divider can accept operands
- `a`  in  W  dividend
- `b`  in  W  divisor
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts result
- `q`  out  W  quotient
- `ovf`  out  1  magnitude overflow; result saturated
- `dbz`  out  1  divide by zero; result saturated

## Operation
- State machine with three states: IDLE, CALC, DONE.
  - IDLE: `in_ready`=1. When `in_valid`, the operands are captured into the state registers, and then:
    - If |b|==0: go to DONE.
    - Otherwise: go to CALC.
  - CALC: K iterations. Each iteration shifts the partial remainder left by 1, brings in the next dividend bit, and subtracts |b| if the result is non-negative. The quotient bit is shifted in. After K iterations, go to DONE.
  - DONE: `out_valid`=1. `q`, `ovf` and `dbz` are held stable until `out_ready`; then go to IDLE.
- Dividend is |a| << N, width MW+N. Divisor is |b|, width MW. K = MW+N iterations.
- Result magnitude is the low MW bits of the quotient.
- Overflow: any quotient bit above MW-1 set → magnitude = all ones, `ovf`=1.
- Divide by zero: magnitude = all ones, sign = sign(a), `dbz`=1, `ovf`=0.
- Sign = sign(a) XOR sign(b), with one exception: a zero magnitude result always has sign 0 (no negative zero).
- Behaviour is the same for zero and non-zero results.
- `in_ready` is deasserted outside IDLE. New operands are never accepted while busy, including during the DONE→IDLE transition cycle.
- Asserting `rst_n`=0 at any time, including mid-CALC, forces IDLE and drops the in-flight operation.

## Timing
- Reset values: `in_ready`=0 while `rst_n`=0, then 1 from the first cycle after deassertion (IDLE). `out_valid`=0, `q`=0, `ovf`=0, `dbz`=0.
- Input handshake on cycle T.
  - Normal case: `out_valid` rises at T+K+1 (T+55 with defaults). With `FIXED_DIV_ROUND_EN`, it rises at T+K+2.
  - Divide by zero: `out_valid` rises at T+1.
- Output is transferred on the cycle `out_valid && out_ready`. The next cycle is IDLE. Minimum spacing between input handshakes is K+2 cycles.
- Outputs are registered only; there is no combinational path from inputs to outputs except `in_ready`, which is a state decode.

## Configuration
- `FIXED_DIV_ROUND_EN` defined:
  - One extra iteration, K = MW+N+1.
  - The extra quotient bit is added to the magnitude (round half up).
  - A carry out of the MW magnitude bits sets `ovf` and saturates the result.
- Undefined: truncation toward zero, K = MW+N.

## Structure
- Shared package `fixed_pkg`:
  - state enum `fixed_div_state_t` (IDLE, CALC, DONE);
  - helpers for W/MW derivation;
  - constant for the saturated magnitude.
- One sub-module is natural: `fixed_div_step`, a combinational restoring cell. It takes (remainder, next bit, divisor) and returns (new remainder, quotient bit), and is instantiated once in the CALC datapath.
- The iteration counter, sized for K, lives in `fixed_div`.

## Test plan
(All values use N=23, M=8; hex values are 32-bit words.)
- Basic divide: `a`=0x00C00000 (1.5), `b`=0x00400000 (0.5) → `q`=0x01800000 (3.0), `ovf`=0, `dbz`=0, `out_valid` exactly 55 cycles after the handshake.
- Sign handling: `a`=0x80C00000 (-1.5), `b`=0x00400000 → `q`=0x81800000. Then `a`=0x80000000 (-0), `b`=0x80400000 → `q`=0x00000000 (no negative zero).
- Overflow: `a`=0x64000000 (200), `b`=0x00400000 (0.5) → `q`=0x7FFFFFFF, `ovf`=1. Repeat with `a`=0xE4000000 → `q`=0xFFFFFFFF, `ovf`=1.
- Divide by zero: `a`=0x00800000, `b`=0x80000000 → `q`=0x7FFFFFFF, `dbz`=1, `out_valid` at T+1.
- Rounding: `a`=0x00800000, `b`=0x01800000 (1/3).
  - Without `FIXED_DIV_ROUND_EN`: `q`=0x002AAAAA.
  - With it: `q`=0x002AAAAB, latency 56 cycles.
- Backpressure and reset:
  - Hold `out_ready`=0 for 10 cycles → `q` stable and `in_ready`=0 throughout.
  - Pulse `rst_n`=0 mid-CALC → next cycle `out_valid`=0 and `q`=0; `in_ready`=1 after release. The next division completes correctly.
